// File: rtl/bitvec_index_encoder.sv
// bitvec_index_encoder
// Captures an N-bit flag vector and replays the index of each set bit,
// lowest first, one index per output handshake. An all-zero vector yields a
// single beat flagged with out_none. All outputs come from registered state.
module bitvec_index_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

    logic         state_q;
    logic         state_d;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;

    // Lowest set bit of pending, isolated as a one-hot word (zero if none).
    logic [N-1:0]     lowest_oh;
    logic [IDX_W-1:0] lowest_idx;
    logic             multi_set;
    logic             emitting;

    assign lowest_oh = pending_q & (~pending_q + N'(1));
    assign multi_set = |(pending_q & (pending_q - N'(1)));
    assign emitting  = (state_q == ST_EMIT);

    // Binary-encode the one-hot lowest bit: index bit gi is the OR of every
    // one-hot position whose own index has bit gi set.
    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
            logic [N-1:0] sel_mask;

            // Constant mask of positions whose index has bit gi set.
            always_comb begin
                sel_mask = '0;
                for (int i = 0; i < N; i++) begin
                    sel_mask[i] = (((i >> gi) & 1) != 0);
                end
            end

            assign lowest_idx[gi] = |(lowest_oh & sel_mask);
        end
    endgenerate

    // Capture is only possible in IDLE and never while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) & rst_n;
    assign out_valid = emitting;
    assign out_idx   = emitting ? lowest_idx : '0;
    assign out_last  = emitting & ~multi_set;
    assign out_none  = emitting & (pending_q == '0);

    // Next-state: capture in IDLE, retire one index per accepted beat in EMIT.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    pending_d = in_vec;
                    state_d   = ST_EMIT;
                end
            end
            default: begin
                if (out_ready) begin
                    if (out_last) begin
                        pending_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        pending_d = pending_q & ~lowest_oh;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any
    // partially emitted vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
